jt10_adpcm_divn: RTL and testbench

// - Iterative quotient/remainder divider, d = a / b, a = b*d + r, for the ADPCM step and rate calculations.
// - Successor to the single-mode radix-2 divider:
//   - configurable bits retired per cycle
//   - optional signed (truncating, C-style) mode
//   - divide-by-zero flag
//   - done strobe
//   - outputs held stable while a new division runs
// - Sits between the register/CPU-side logic and the ADPCM engine; clocked on the CPU clock, gated by cen.

---
 rtl/jt10_adpcm_divn.sv | 144 ++++++++++++++
 tb/tb_jt10_adpcm_divn.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/jt10_adpcm_divn.sv
// Iterative restoring divider d = a / b, r = a - b*d, retiring BPC quotient bits per cen cycle.
// Optional C-style signed mode, divide-by-zero flag and one-cen-period done strobe.

module jt10_adpcm_divn_stage #(
   parameter int DW = 16
) (
   input  logic [DW-1:0] babs,
   input  logic [DW-1:0] rem_in,
   input  logic [DW-1:0] quo_in,
   output logic [DW-1:0] rem_out,
   output logic [DW-1:0] quo_out
);
   logic [DW:0] sh;
   logic        ge;

   // When the trial subtraction succeeds the true difference is below 2^DW,
   // so a DW-bit subtract of the low bits is exact.
   assign sh      = {rem_in, quo_in[DW-1]};
   assign ge      = sh >= {1'b0, babs};
   assign rem_out = ge ? sh[DW-1:0] - babs : sh[DW-1:0];
   assign quo_out = {quo_in[DW-2:0], ge};
endmodule

module jt10_adpcm_divn #(
   parameter int DW        = 16,
   parameter int BPC       = 1,
   parameter int SIGNED_EN = 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          cen,
   input  logic          start,
   input  logic          sgn,
   input  logic [DW-1:0] a,
   input  logic [DW-1:0] b,
   output logic [DW-1:0] d,
   output logic [DW-1:0] r,
   output logic          dz,
   output logic          busy,
   output logic          done
);
   localparam int N  = DW / BPC;
   localparam int CW = $clog2(N + 1);

   typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

   state_t           st, st_nx;
   logic [CW-1:0]    cnt;
   logic [DW-1:0]    rem, quo, babs, a_lat;
   logic             sq, sr, dz_int;
   logic             sgn_eff, a_neg, b_neg;
   logic [DW-1:0]    a_mag, b_mag;
   logic [BPC:0][DW-1:0] rem_c, quo_c;

   assign sgn_eff = (SIGNED_EN != 0) && sgn;
   assign a_neg   = sgn_eff & a[DW-1];
   assign b_neg   = sgn_eff & b[DW-1];
   // Magnitudes stay DW bits wide, so the most negative value maps exactly.
   assign a_mag   = a_neg ? -a : a;
   assign b_mag   = b_neg ? -b : b;

   assign rem_c[0] = rem;
   assign quo_c[0] = quo;

   genvar g;
   generate
      for (g = 0; g < BPC; g++) begin : g_stage
         jt10_adpcm_divn_stage #(.DW(DW)) u_stage (
            .babs    (babs),
            .rem_in  (rem_c[g]),
            .quo_in  (quo_c[g]),
            .rem_out (rem_c[g+1]),
            .quo_out (quo_c[g+1])
         );
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)   st <= IDLE;
      else if (cen) st <= st_nx;
   end

   always_comb begin
      st_nx = st;
      case (st)
         IDLE:    if (start) st_nx = CALC;
         CALC:    if (cnt == CW'(N - 1)) st_nx = FIX;
         FIX:     st_nx = IDLE;
         default: st_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt    <= '0;
         rem    <= '0;
         quo    <= '0;
         babs   <= '0;
         a_lat  <= '0;
         sq     <= 1'b0;
         sr     <= 1'b0;
         dz_int <= 1'b0;
         d      <= '0;
         r      <= '0;
         dz     <= 1'b0;
         busy   <= 1'b0;
         done   <= 1'b0;
      end else if (cen) begin
         done <= 1'b0;
         case (st)
            IDLE: if (start) begin
               quo    <= a_mag;
               babs   <= b_mag;
               rem    <= '0;
               a_lat  <= a;
               sq     <= a_neg ^ b_neg;
               sr     <= a_neg;
               dz_int <= (b == '0);
               cnt    <= '0;
               busy   <= 1'b1;
            end
            CALC: begin
               rem <= rem_c[BPC];
               quo <= quo_c[BPC];
               cnt <= cnt + 1'b1;
            end
            FIX: begin
               // Outputs move only here, so they hold the old result during CALC.
               if (dz_int) begin
                  d <= '1;
                  r <= a_lat;
               end else begin
                  d <= sq ? -quo : quo;
                  r <= sr ? -rem : rem;
               end
               dz   <= dz_int;
               done <= 1'b1;
               busy <= 1'b0;
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_jt10_adpcm_divn.sv
// Scoreboard bench for jt10_adpcm_divn at BPC=1, 2 and 4 driven with shared stimulus.
// A C-semantics reference model supplies expected quotient/remainder for random operands.

module tb_jt10_adpcm_divn;
   typedef struct {
      logic [15:0] d;
      logic [15:0] r;
      logic        dz;
      int          t;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        cen = 1'b1;
   logic        start = 1'b0;
   logic        sgn = 1'b0;
   logic [15:0] a = '0, b = '0;
   logic [15:0] d_o [3];
   logic [15:0] r_o [3];
   logic        dz_o [3];
   logic        busy_o [3];
   logic        done_o [3];

   exp_t        q [3][$];
   logic [15:0] last_d [3] = '{default: '0};
   logic [15:0] last_r [3] = '{default: '0};
   logic        last_dz [3] = '{default: 1'b0};
   logic        prev_done [3] = '{default: 1'b0};
   int          lat [3] = '{17, 9, 5};
   int          ecount = 0;
   logic        last_cen = 1'b0;
   int          vec = 0;
   int          mis = 0;

   jt10_adpcm_divn #(.DW(16), .BPC(1), .SIGNED_EN(1)) u_div1 (
      .clk(clk), .rst_n(rst_n), .cen(cen), .start(start), .sgn(sgn), .a(a), .b(b),
      .d(d_o[0]), .r(r_o[0]), .dz(dz_o[0]), .busy(busy_o[0]), .done(done_o[0]));
   jt10_adpcm_divn #(.DW(16), .BPC(2), .SIGNED_EN(1)) u_div2 (
      .clk(clk), .rst_n(rst_n), .cen(cen), .start(start), .sgn(sgn), .a(a), .b(b),
      .d(d_o[1]), .r(r_o[1]), .dz(dz_o[1]), .busy(busy_o[1]), .done(done_o[1]));
   jt10_adpcm_divn #(.DW(16), .BPC(4), .SIGNED_EN(1)) u_div4 (
      .clk(clk), .rst_n(rst_n), .cen(cen), .start(start), .sgn(sgn), .a(a), .b(b),
      .d(d_o[2]), .r(r_o[2]), .dz(dz_o[2]), .busy(busy_o[2]), .done(done_o[2]));

   initial forever #5 clk = ~clk;

   always @(posedge clk) begin
      last_cen <= cen;
      if (cen) ecount <= ecount + 1;
   end

   // Output monitor: pops the scoreboard on done, otherwise checks results hold.
   always @(negedge clk) begin
      if (rst_n && last_cen) begin
         for (int i = 0; i < 3; i++) begin
            if (done_o[i]) begin
               vec++;
               if (prev_done[i]) begin
                  mis++;
                  $display("FAIL done_width inst%0d: done high on two consecutive cen edges", i);
               end
               vec++;
               if (q[i].size() == 0) begin
                  mis++;
                  $display("FAIL spurious_done inst%0d: done=1 with no division outstanding", i);
               end else begin
                  exp_t e;
                  e = q[i].pop_front();
                  vec++;
                  if ({d_o[i], r_o[i], dz_o[i]} !== {e.d, e.r, e.dz}) begin
                     mis++;
                     $display("FAIL result inst%0d: got d=%h r=%h dz=%b, want d=%h r=%h dz=%b",
                              i, d_o[i], r_o[i], dz_o[i], e.d, e.r, e.dz);
                  end
                  vec++;
                  if (ecount - e.t !== lat[i]) begin
                     mis++;
                     $display("FAIL latency inst%0d: got %0d cen edges, want %0d", i, ecount - e.t, lat[i]);
                  end
                  last_d[i]  = e.d;
                  last_r[i]  = e.r;
                  last_dz[i] = e.dz;
               end
            end else begin
               vec++;
               if ({d_o[i], r_o[i], dz_o[i]} !== {last_d[i], last_r[i], last_dz[i]}) begin
                  mis++;
                  $display("FAIL hold inst%0d: got d=%h r=%h dz=%b, want d=%h r=%h dz=%b",
                           i, d_o[i], r_o[i], dz_o[i], last_d[i], last_r[i], last_dz[i]);
               end
            end
            vec++;
            if (busy_o[i] !== (q[i].size() != 0)) begin
               mis++;
               $display("FAIL busy inst%0d: got %b, want %b", i, busy_o[i], q[i].size() != 0);
            end
            prev_done[i] = done_o[i];
         end
      end
   end

   function automatic exp_t ref_div(input logic [15:0] av, input logic [15:0] bv, input logic s);
      exp_t e;
      int   x, y, qq, rr;
      e.t = 0;
      if (bv == 16'h0) begin
         e.d = 16'hFFFF; e.r = av; e.dz = 1'b1;
      end else begin
         if (s) begin
            x = $signed(av); y = $signed(bv);
         end else begin
            x = {16'h0, av}; y = {16'h0, bv};
         end
         qq = x / y;
         rr = x % y;
         e.d = qq[15:0]; e.r = rr[15:0]; e.dz = 1'b0;
      end
      return e;
   endfunction

   // Called at negedge+1; the start is seen by the following posedge.
   task automatic drive_start(input logic [15:0] av, input logic [15:0] bv, input logic s,
                              input logic [15:0] ed, input logic [15:0] er, input logic edz);
      exp_t e;
      e.d = ed; e.r = er; e.dz = edz; e.t = ecount + 1;
      cen = 1'b1; start = 1'b1; a = av; b = bv; sgn = s;
      for (int i = 0; i < 3; i++) if (q[i].size() == 0) q[i].push_back(e);
      @(negedge clk); #1;
      start = 1'b0; a = 16'($urandom); b = 16'($urandom); sgn = 1'($urandom);
   endtask

   task automatic run_ref(input logic [15:0] av, input logic [15:0] bv, input logic s);
      exp_t e;
      e = ref_div(av, bv, s);
      drive_start(av, bv, s, e.d, e.r, e.dz);
   endtask

   task automatic clear_sb();
      for (int i = 0; i < 3; i++) begin
         q[i].delete();
         last_d[i] = '0; last_r[i] = '0; last_dz[i] = 1'b0; prev_done[i] = 1'b0;
      end
   endtask

   // mode 0: cen always high, 1: cen 1-in-3, 2: cen random.
   task automatic wait_idle(input int mode);
      int n = 0;
      while ((q[0].size() + q[1].size() + q[2].size()) != 0 && n < 400) begin
         @(negedge clk); #1;
         n++;
         case (mode)
            1:       cen = (n % 3 == 0);
            2:       cen = ($urandom_range(0, 3) != 0);
            default: cen = 1'b1;
         endcase
      end
      cen = 1'b1;
      vec++;
      if (n >= 400) begin
         mis++;
         $display("FAIL wait_idle: results still outstanding after %0d cycles, want 0", n);
         clear_sb();
      end
   endtask

   task automatic check_zero(input string tag);
      for (int i = 0; i < 3; i++) begin
         vec++;
         if ({d_o[i], r_o[i], dz_o[i], busy_o[i], done_o[i]} !== 35'h0) begin
            mis++;
            $display("FAIL %s inst%0d: got d=%h r=%h dz=%b busy=%b done=%b, want all 0",
                     tag, i, d_o[i], r_o[i], dz_o[i], busy_o[i], done_o[i]);
         end
      end
   endtask

   task automatic test_reset();
      #2 rst_n = 1'b0;
      #3 check_zero("reset");
      clear_sb();
      @(negedge clk); #1 rst_n = 1'b1;
      @(negedge clk); #1;
   endtask

   task automatic test_unsigned();
      drive_start(16'd1000, 16'd7, 1'b0, 16'd142, 16'd6, 1'b0);   wait_idle(0);
      drive_start(16'hFFFF, 16'h0010, 1'b0, 16'h0FFF, 16'h000F, 1'b0); wait_idle(0);
      drive_start(16'd5, 16'd9, 1'b0, 16'd0, 16'd5, 1'b0);        wait_idle(0);
      drive_start(16'h8000, 16'hFFFF, 1'b0, 16'h0000, 16'h8000, 1'b0); wait_idle(0);
   endtask

   task automatic test_signed();
      drive_start(16'hFFF9, 16'h0002, 1'b1, 16'hFFFD, 16'hFFFF, 1'b0); wait_idle(0);
      drive_start(16'h8000, 16'hFFFF, 1'b1, 16'h8000, 16'h0000, 1'b0); wait_idle(0);
      drive_start(16'h0007, 16'hFFFE, 1'b1, 16'hFFFD, 16'h0001, 1'b0); wait_idle(0);
      drive_start(16'hFFF9, 16'hFFFE, 1'b1, 16'h0003, 16'hFFFF, 1'b0); wait_idle(0);
   endtask

   task automatic test_div_zero();
      drive_start(16'h1234, 16'h0000, 1'b0, 16'hFFFF, 16'h1234, 1'b1); wait_idle(0);
      drive_start(16'h1234, 16'h0000, 1'b1, 16'hFFFF, 16'h1234, 1'b1); wait_idle(0);
      drive_start(16'h8001, 16'h0000, 1'b1, 16'hFFFF, 16'h8001, 1'b1); wait_idle(0);
      drive_start(16'd1000, 16'd7, 1'b0, 16'd142, 16'd6, 1'b0);       wait_idle(0);
   endtask

   task automatic test_cen_stretch();
      drive_start(16'hFFFF, 16'h0010, 1'b0, 16'h0FFF, 16'h000F, 1'b0); wait_idle(1);
      drive_start(16'hFFF9, 16'h0002, 1'b1, 16'hFFFD, 16'hFFFF, 1'b0); wait_idle(1);
   endtask

   task automatic test_busy_ignore();
      drive_start(16'd1000, 16'd7, 1'b0, 16'd142, 16'd6, 1'b0);
      repeat (3) begin @(negedge clk); #1; end
      // All three instances are still busy, so nothing is expected from this start.
      drive_start(16'hFFFF, 16'h0010, 1'b0, 16'h0FFF, 16'h000F, 1'b0);
      wait_idle(0);
   endtask

   task automatic test_back_to_back();
      int n = 0;
      drive_start(16'd1000, 16'd7, 1'b0, 16'd142, 16'd6, 1'b0);
      while (q[0].size() != 0 && n < 100) begin @(negedge clk); #1; n++; end
      vec++;
      if (n >= 100) begin
         mis++;
         $display("FAIL back_to_back: first division not done after %0d cycles, want <= 18", n);
      end
      drive_start(16'hFFF9, 16'h0002, 1'b1, 16'hFFFD, 16'hFFFF, 1'b0);
      wait_idle(0);
   endtask

   task automatic test_reset_mid();
      drive_start(16'hFFFF, 16'd3, 1'b0, 16'h5555, 16'h0000, 1'b0);
      repeat (3) begin @(negedge clk); #1; end
      rst_n = 1'b0;
      #1 check_zero("reset_mid");
      clear_sb();
      @(negedge clk); #1 rst_n = 1'b1;
      @(negedge clk); #1;
      drive_start(16'd1000, 16'd7, 1'b0, 16'd142, 16'd6, 1'b0);
      wait_idle(0);
   endtask

   task automatic test_random();
      logic [15:0] av, bv;
      for (int k = 0; k < 1500; k++) begin
         av = 16'($urandom);
         case ($urandom_range(0, 7))
            0:       bv = 16'h0;
            1, 2:    bv = 16'($urandom_range(1, 15));
            3:       bv = -16'($urandom_range(1, 15));
            default: bv = 16'($urandom);
         endcase
         run_ref(av, bv, 1'($urandom));
         wait_idle(k % 4 == 0 ? 2 : 0);
      end
   endtask

   initial begin
      test_reset();
      test_unsigned();
      test_signed();
      test_div_zero();
      test_cen_stretch();
      test_busy_ignore();
      test_back_to_back();
      test_reset_mid();
      test_random();
      repeat (2) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", vec, mis);
      $finish;
   end
endmodule
